dmem_wait_resp: RTL and testbench

Data-memory responder for the MIPS pipeline's load/store port. It accepts one word or store-byte access at a time from the processor, holds it for a parameterised number of wait states, then completes it with a one-cycle acknowledge. While an access is outstanding it drives a stall back to the pipeline. It is the memory-side end of the processor's data interface and is a drop-in replacement for a zero-latency data memory when memory latency is modelled.

---
 rtl/dmem_wait_resp.sv | 160 ++++++++++++++++
 tb/tb_dmem_wait_resp.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait_resp.sv
// dmem_wait_resp: data-memory responder for the pipeline load/store port.
// Accepts one access at a time. It holds the access for WAIT cycles, then
// acknowledges it for one cycle. It stalls the pipeline while the access is
// outstanding.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no access outstanding, req is sampled here only
//   ST_WAIT | access captured, wait counter running down
//   ST_RESP | ack/err/rdata presented, store commits on the edge leaving
module dmem_wait_resp #(
   parameter int DEPTH_LOG2 = 6,
   parameter int WAIT       = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        sb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        err,
   output logic        stall
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam int         DEPTH   = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LD = 4'(WAIT);

   logic [31:0]           mem_q [DEPTH];

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic                  we_q;
   logic                  sb_q;
   logic                  misal_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [1:0]            lane_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  ack_q;
   logic                  err_q;

   logic [DEPTH_LOG2-1:0] idx_in;
   logic                  misal_in;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic                  acc_misal;
   logic [31:0]           wr_word;
   logic                  commit;
   logic                  unused_addr;

   // Upper address bits alias onto the array and are deliberately dropped.
   assign unused_addr = ^addr[31:DEPTH_LOG2+2];

   assign idx_in   = addr[DEPTH_LOG2+1:2];
   // Byte stores ignore alignment. A load is misaligned whenever addr[1:0] != 0.
   assign misal_in = (addr[1:0] != 2'b00) && !(we && sb);

   // In IDLE the access that is being accepted comes straight from the ports.
   // Otherwise it comes from the captured copy.
   always_comb begin
      acc_idx   = idx_q;
      acc_misal = misal_q;
      if (state_q == ST_IDLE) begin
         acc_idx   = idx_in;
         acc_misal = misal_in;
      end
   end

   // Merge the store byte into its little-endian lane.
   // Word stores replace the whole word.
   always_comb begin
      wr_word = wdata_q;
      if (sb_q) begin
         wr_word = mem_q[idx_q];
         case (lane_q)
            2'd0:    wr_word[7:0]   = wdata_q[7:0];
            2'd1:    wr_word[15:8]  = wdata_q[7:0];
            2'd2:    wr_word[23:16] = wdata_q[7:0];
            default: wr_word[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // A misaligned word store is dropped. A reset that hits RESP has already
   // moved the state back to IDLE, so no commit happens.
   assign commit = (state_q == ST_RESP) && we_q && (sb_q || !misal_q);

   // Sequencer: capture, count down, and present a one-cycle response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         sb_q    <= 1'b0;
         misal_q <= 1'b0;
         idx_q   <= '0;
         lane_q  <= 2'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  we_q    <= we;
                  sb_q    <= sb;
                  misal_q <= misal_in;
                  idx_q   <= idx_in;
                  lane_q  <= addr[1:0];
                  wdata_q <= wdata;
                  cnt_q   <= WAIT_LD;
                  if (WAIT == 0) begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     err_q   <= acc_misal;
                     rdata_q <= mem_q[acc_idx];
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  err_q   <= acc_misal;
                  rdata_q <= mem_q[acc_idx];
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage array. The contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!reset && commit) begin
         mem_q[idx_q] <= wr_word;
      end
   end

   assign rdata = rdata_q;
   assign ack   = ack_q;
   assign err   = err_q;
   assign stall = req & ~ack_q;

endmodule

// File: tb/tb_dmem_wait_resp.sv
// Bench for dmem_wait_resp: one instance with WAIT=2 and one with WAIT=0.
// Each expected response is queued when its access is issued. Per-DUT monitors
// pop the queue and compare on every ack.
module tb_dmem_wait_resp;

   logic        clk = 1'b0;
   logic        reset;
   logic        req2, req0, we, sb;
   logic [31:0] addr, wdata;
   logic [31:0] rdata2, rdata0;
   logic        ack2, err2, stall2;
   logic        ack0, err0, stall0;

   always #5 clk = ~clk;

   dmem_wait_resp #(.DEPTH_LOG2(6), .WAIT(2)) u_w2 (
      .clk(clk), .reset(reset), .req(req2), .we(we), .sb(sb), .addr(addr),
      .wdata(wdata), .rdata(rdata2), .ack(ack2), .err(err2), .stall(stall2)
   );

   dmem_wait_resp #(.DEPTH_LOG2(6), .WAIT(0)) u_w0 (
      .clk(clk), .reset(reset), .req(req0), .we(we), .sb(sb), .addr(addr),
      .wdata(wdata), .rdata(rdata0), .ack(ack0), .err(err0), .stall(stall0)
   );

   typedef struct {
      logic [31:0] rd;
      logic        er;
      bit          chk;
   } exp_t;

   exp_t q2[$];
   exp_t q0[$];
   exp_t e2, e0;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the WAIT=2 instance.
   always @(negedge clk) begin
      if (err2 === 1'b1 && ack2 !== 1'b1) check("err2_without_ack", {31'd0, err2}, 32'd0);
      if (ack2 === 1'b1) begin
         if (q2.size() == 0) begin
            check("ack2_unexpected", {31'd0, ack2}, 32'd0);
         end else begin
            e2 = q2.pop_front();
            if (e2.chk) check("rdata2", rdata2, e2.rd);
            check("err2", {31'd0, err2}, {31'd0, e2.er});
         end
      end
   end

   // Monitor for the WAIT=0 instance.
   always @(negedge clk) begin
      if (err0 === 1'b1 && ack0 !== 1'b1) check("err0_without_ack", {31'd0, err0}, 32'd0);
      if (ack0 === 1'b1) begin
         if (q0.size() == 0) begin
            check("ack0_unexpected", {31'd0, ack0}, 32'd0);
         end else begin
            e0 = q0.pop_front();
            if (e0.chk) check("rdata0", rdata0, e0.rd);
            check("err0", {31'd0, err0}, {31'd0, e0.er});
         end
      end
   end

   // Issue one access at posedge+1 and hold req until the ack cycle ends.
   // Check stall while waiting and check the ack latency.
   task automatic access(input bit sel0, input bit w, input bit b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input bit ee, input bit chk,
                         input int lat);
      exp_t e;
      int   k;
      e.rd = er; e.er = ee; e.chk = chk;
      if (sel0) q0.push_back(e); else q2.push_back(e);
      we = w; sb = b; addr = a; wdata = d;
      if (sel0) req0 = 1'b1; else req2 = 1'b1;
      #1;
      check("stall_on_req", {31'd0, sel0 ? stall0 : stall2}, 32'd1);
      k = -1;
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         if ((sel0 ? ack0 : ack2) === 1'b1) begin
            k = i;
            break;
         end
         check("stall_hold", {31'd0, sel0 ? stall0 : stall2}, 32'd1);
      end
      check("ack_latency", k, lat);
      check("stall_in_ack", {31'd0, sel0 ? stall0 : stall2}, 32'd0);
      @(posedge clk); #1;
      if (sel0) req0 = 1'b0; else req2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req2 = 1'b0; req0 = 1'b0; we = 1'b0; sb = 1'b0;
      addr = 32'd0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ack2",   {31'd0, ack2},   32'd0);
      check("rst_err2",   {31'd0, err2},   32'd0);
      check("rst_rdata2", rdata2,          32'd0);
      check("rst_stall2", {31'd0, stall2}, 32'd0);
      check("rst_rdata0", rdata0,          32'd0);
      check("rst_ack0",   {31'd0, ack0},   32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // WAIT=2: word store/load, byte lanes, misaligned word accesses.
      //     sel0 we sb addr          wdata         exp rdata     err chk lat
      access(0, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 3);
      access(0, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, 3);
      access(0, 1, 0, 32'h20, 32'h11223344, 32'h0,        0, 0, 3);
      access(0, 1, 1, 32'h22, 32'hFFFFFFAA, 32'h11223344, 0, 1, 3);
      access(0, 0, 0, 32'h20, 32'h0,        32'h11AA3344, 0, 1, 3);
      access(0, 1, 1, 32'h23, 32'h12345655, 32'h11AA3344, 0, 1, 3);
      access(0, 0, 0, 32'h20, 32'h0,        32'h55AA3344, 0, 1, 3);
      access(0, 1, 0, 32'h21, 32'hFFFFFFFF, 32'h55AA3344, 1, 1, 3);
      access(0, 0, 0, 32'h20, 32'h0,        32'h55AA3344, 0, 1, 3);
      access(0, 0, 0, 32'h22, 32'h0,        32'h55AA3344, 1, 1, 3);
      access(0, 1, 1, 32'h21, 32'hABCDEF77, 32'h55AA3344, 0, 1, 3);
      access(0, 1, 1, 32'h20, 32'h00000099, 32'h55AA7744, 0, 1, 3);
      access(0, 0, 0, 32'h20, 32'h0,        32'h55AA7799, 0, 1, 3);

      // WAIT=0: single-cycle latency and address aliasing.
      access(1, 1, 0, 32'h04,  32'h12345678, 32'h0,        0, 0, 1);
      access(1, 0, 0, 32'h104, 32'h0,        32'h12345678, 0, 1, 1);

      // WAIT=0 with req held high: an ack every second cycle, with no double accept.
      for (int i = 0; i < 4; i++) q0.push_back('{rd: 32'h12345678, er: 1'b0, chk: 1'b1});
      we = 1'b0; sb = 1'b0; addr = 32'h104; req0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("b2b_ack_pattern", {31'd0, ack0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk); #1;

      // Reset during WAIT: no ack, and the store is dropped.
      access(0, 1, 0, 32'h30, 32'h0BADC0DE, 32'h0, 0, 0, 3);
      we = 1'b1; sb = 1'b0; addr = 32'h30; wdata = 32'hCAFEF00D; req2 = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("midrst_ack",   {31'd0, ack2}, 32'd0);
      check("midrst_rdata", rdata2,        32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset during RESP, just after ack rises: ack is cleared and the commit is dropped.
      req2 = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("resprst_ack", {31'd0, ack2}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; req2 = 1'b0;
      @(posedge clk); #1;
      access(0, 0, 0, 32'h30, 32'h0, 32'h0BADC0DE, 0, 1, 3);

      repeat (3) @(posedge clk);
      check("q2_drained", q2.size(), 32'd0);
      check("q0_drained", q0.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
